// File: rtl/perf_event_counter_if.sv
// Control, event and readout signals of the pipeline performance monitor.
interface perf_event_counter_if #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEL_W   = 4
);
  logic               start_i;
  logic               clr_i;
  logic [NUM_EVT-1:0] evt_i;
  logic               snap_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic               snap_valid_o;
  logic               running_o;
  logic               done_o;
  logic [NUM_EVT:0]   ovf_o;

  // Driver side (CPU event wiring / software).
  modport master (
    output start_i, clr_i, evt_i, snap_i, rd_sel_i,
    input  rd_data_o, snap_valid_o, running_o, done_o, ovf_o
  );

  // Counter block side.
  modport slave (
    input  start_i, clr_i, evt_i, snap_i, rd_sel_i,
    output rd_data_o, snap_valid_o, running_o, done_o, ovf_o
  );
endinterface

// File: rtl/perf_event_counter.sv
// Pipeline performance monitor: run-cycle counter plus NUM_EVT event counters,
// optional cycle limit, wrap/saturate overflow and atomic snapshot readout.
// Counter index 0 is the cycle counter, index k is event channel k-1.
// Interface parameters must match the module parameters.
module perf_event_counter #(
  parameter int unsigned NUM_EVT    = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned SAT        = 0,
  parameter int unsigned SEL_W      = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  perf_event_counter_if.slave  bus
);

  localparam int unsigned NC = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] Ones = '1;
  localparam logic [CNT_W-1:0] LastCyc =
      (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NC];
  logic [CNT_W-1:0] cnt_d [NC];
  logic [CNT_W-1:0] shd_q [NC];
  logic [CNT_W-1:0] shd_d [NC];
  logic [NUM_EVT:0] ovf_q, ovf_d;
  logic [NUM_EVT:0] inc;
  logic             snap_take;
  logic             snap_valid_q;

  // Next-state FSM, counter increments with overflow handling, clear priority.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    inc     = '0;
    for (int unsigned i = 0; i < NC; i++) cnt_d[i] = cnt_q[i];

    inc[0] = (state_q == StRun) && bus.start_i;
    for (int unsigned k = 0; k < NUM_EVT; k++) inc[k+1] = inc[0] & bus.evt_i[k];

    for (int unsigned i = 0; i < NC; i++) begin
      if (inc[i]) begin
        if (cnt_q[i] == Ones) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT != 0) ? Ones : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    unique case (state_q)
      StIdle: if (bus.start_i) state_d = StRun;
      StRun: begin
        if (!bus.start_i) begin
          state_d = StIdle;
        end else if ((MAX_CYCLES != 0) && (cnt_q[0] == LastCyc)) begin
          // Limit edge still counts its events, then freezes.
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase

    if (bus.clr_i) begin
      state_d = StIdle;
      ovf_d   = '0;
      for (int unsigned i = 0; i < NC; i++) cnt_d[i] = '0;
    end
  end

  // Shadow load uses post-edge live values so same-edge increments are included.
  always_comb begin
    snap_take = bus.snap_i & ~bus.clr_i;
    for (int unsigned i = 0; i < NC; i++) shd_d[i] = snap_take ? cnt_d[i] : shd_q[i];
  end

  // State, counters, shadows and flags with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NC; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_take;
      for (int unsigned i = 0; i < NC; i++) begin
        cnt_q[i] <= cnt_d[i];
        shd_q[i] <= shd_d[i];
      end
    end
  end

  // Combinational shadow readout; out-of-range selects read zero.
  always_comb begin
    bus.rd_data_o = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (bus.rd_sel_i == SEL_W'(i)) bus.rd_data_o = shd_q[i];
    end
  end

  assign bus.snap_valid_o = snap_valid_q;
  assign bus.running_o    = (state_q == StRun);
  assign bus.done_o       = (state_q == StDone);
  assign bus.ovf_o        = ovf_q;

endmodule
